multi_scrolling_display: RTL and testbench

MULTI_SCROLLING_DISPLAY -- requirements
Module: multi_scrolling_display

---
 rtl/display_layout_pkg.sv | 28 ++
 rtl/multi_scrolling_display_if.sv | 12 +
 rtl/channel_ring_buffer.sv | 83 ++++++++
 rtl/multi_scrolling_display.sv | 89 ++++++++
 tb/tb_multi_scrolling_display.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_layout_pkg.sv
// Shared band layout defaults, band geometry helpers and the 24-bit colour type
// used by the scrolling trace display.
package display_layout_pkg;

    localparam int COLOR_W             = 24;
    localparam int DEFAULT_TOP_ROW     = 32;
    localparam int DEFAULT_BAND_HEIGHT = 16;
    localparam int DEFAULT_GAP_HEIGHT  = 48;

    typedef logic [COLOR_W-1:0] color_t;

    function automatic int band_start(input int k, input int top_row,
                                      input int band_height, input int gap_height);
        return top_row + k * (band_height + gap_height);
    endfunction

    function automatic logic in_band(input logic [9:0] row, input int k, input int top_row,
                                     input int band_height, input int gap_height);
        int start;
        start = band_start(k, top_row, band_height, gap_height);
        return (int'(row) >= start) && (int'(row) < start + band_height);
    endfunction

    function automatic color_t grey(input logic [7:0] level);
        return {level, level, level};
    endfunction

endpackage

// File: rtl/multi_scrolling_display_if.sv
// Per-channel sample stream: packed samples, per-channel strobes and accept flags.
interface multi_scrolling_display_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] sink_data;
    logic [NUM_CHANNELS-1:0]            sink_valid;
    logic [NUM_CHANNELS-1:0]            sink_ready;

    modport master (output sink_data, output sink_valid, input sink_ready);
    modport slave  (input sink_data, input sink_valid, output sink_ready);
endinterface

// File: rtl/channel_ring_buffer.sv
// One trace: circular sample RAM with write pointer, saturating fill count and a
// per-frame snapshot that the read side uses so a frame never tears.
module channel_ring_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  snap_en,
    input  logic [9:0]            rd_col,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  col_show
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q, snap_ptr_d, snap_ptr_q, rd_addr;
    logic [CNT_W-1:0]      fill_d, fill_q, snap_fill_d, snap_fill_q;
    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
    logic                  col_show_d, col_show_q;
    logic [10:0]           addr_sum;

    // The snapshot takes the pre-write pointer, so a write in the snapshot cycle lands next frame.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        snap_ptr_d  = snap_ptr_q;
        snap_fill_d = snap_fill_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (fill_q != CNT_W'(DEPTH)) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
        if (snap_en) begin
            snap_ptr_d  = wr_ptr_q;
            snap_fill_d = fill_q;
        end
    end

    always_comb begin
        addr_sum = 11'(snap_ptr_q) + 11'(rd_col);
        if (addr_sum >= 11'(DEPTH)) begin
            addr_sum = addr_sum - 11'(DEPTH);
        end
        rd_addr    = (11'(rd_col) < 11'(DEPTH)) ? PTR_W'(addr_sum) : '0;
        rd_data_d  = mem[rd_addr];
        col_show_d = (11'(rd_col) < 11'(DEPTH)) &&
                     (11'(rd_col) >= 11'(DEPTH) - 11'(snap_fill_q));
    end

    // Sample storage is deliberately left uninitialised; the fill mask hides stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            snap_ptr_q  <= '0;
            snap_fill_q <= '0;
            rd_data_q   <= '0;
            col_show_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            snap_ptr_q  <= snap_ptr_d;
            snap_fill_q <= snap_fill_d;
            rd_data_q   <= rd_data_d;
            col_show_q  <= col_show_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign col_show = col_show_q;

endmodule

// File: rtl/multi_scrolling_display.sv
// Multi-channel scrolling trace display: each channel feeds a ring buffer drawn as a
// grey horizontal band, with a two-cycle pixel pipeline from coordinates to colour.
module multi_scrolling_display
    import display_layout_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 480,
    parameter int TOP_ROW      = DEFAULT_TOP_ROW,
    parameter int BAND_HEIGHT  = DEFAULT_BAND_HEIGHT,
    parameter int GAP_HEIGHT   = DEFAULT_GAP_HEIGHT
) (
    input  logic                             display_clk,
    input  logic                             reset_n,
    input  logic [9:0]                       h_pos,
    input  logic [9:0]                       v_pos,
    input  logic                             valid_draw,
    input  logic                             freeze,
    multi_scrolling_display_if.slave         sink,
    output logic [7:0]                       disp_red,
    output logic [7:0]                       disp_green,
    output logic [7:0]                       disp_blue
);
    localparam int BIDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                    snap_en;
    logic [DATA_WIDTH-1:0]   rd_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] col_show;
    logic                    band_hit_d, band_hit_q;
    logic [BIDX_W-1:0]       band_idx_d, band_idx_q;
    logic                    valid_d, valid_q;
    color_t                  pix_d, pix_q;

    assign sink.sink_ready = {NUM_CHANNELS{~freeze}};
    assign snap_en         = (h_pos == '0) && (v_pos == '0);

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
        channel_ring_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_buf (
            .clk      (display_clk),
            .rst_n    (reset_n),
            .wr_en    (sink.sink_valid[k] & ~freeze),
            .wr_data  (sink.sink_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .snap_en  (snap_en),
            .rd_col   (h_pos),
            .rd_data  (rd_data[k]),
            .col_show (col_show[k])
        );
    end

    // Band decode runs in the same stage as the RAM read so both arrive together.
    always_comb begin
        band_hit_d = 1'b0;
        band_idx_d = '0;
        valid_d    = valid_draw;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (in_band(v_pos, k, TOP_ROW, BAND_HEIGHT, GAP_HEIGHT)) begin
                band_hit_d = 1'b1;
                band_idx_d = BIDX_W'(k);
            end
        end
    end

    always_comb begin
        pix_d = '0;
        if (valid_q && band_hit_q && col_show[band_idx_q]) begin
            pix_d = grey(rd_data[band_idx_q][DATA_WIDTH-1 -: 8]);
        end
    end

    always_ff @(posedge display_clk or negedge reset_n) begin
        if (!reset_n) begin
            band_hit_q <= 1'b0;
            band_idx_q <= '0;
            valid_q    <= 1'b0;
            pix_q      <= '0;
        end else begin
            band_hit_q <= band_hit_d;
            band_idx_q <= band_idx_d;
            valid_q    <= valid_d;
            pix_q      <= pix_d;
        end
    end

    assign {disp_red, disp_green, disp_blue} = pix_q;

endmodule

// File: tb/tb_multi_scrolling_display.sv
// Randomised and directed bench for multi_scrolling_display against a sample-history
// model of what each band should show.
module tb_multi_scrolling_display;
    localparam int NCH      = 4;
    localparam int DW       = 12;
    localparam int DEPTH    = 480;
    localparam int TOP      = 32;
    localparam int BH       = 16;
    localparam int GAP      = 48;
    localparam int HIST_MAX = 4096;

    typedef struct {
        int          h;
        int          v;
        logic [23:0] exp;
    } pix_t;

    logic        display_clk = 1'b0;
    logic        reset_n     = 1'b0;
    logic [9:0]  h_pos       = '0;
    logic [9:0]  v_pos       = '0;
    logic        valid_draw  = 1'b0;
    logic        freeze      = 1'b0;
    logic [7:0]  disp_red, disp_green, disp_blue;

    multi_scrolling_display_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) sink ();

    multi_scrolling_display #(
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .TOP_ROW      (TOP),
        .BAND_HEIGHT  (BH),
        .GAP_HEIGHT   (GAP)
    ) dut (
        .display_clk (display_clk),
        .reset_n     (reset_n),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .valid_draw  (valid_draw),
        .freeze      (freeze),
        .sink        (sink),
        .disp_red    (disp_red),
        .disp_green  (disp_green),
        .disp_blue   (disp_blue)
    );

    always #5 display_clk = ~display_clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [DW-1:0] hist_mem [NCH][HIST_MAX];
    int          hist_cnt [NCH];
    int          snap_cnt [NCH];
    pix_t        exp_q [$];
    int          row_bad, bad_h, bad_v;
    logic [23:0] bad_obs, bad_exp;
    int          probe_h [2];
    int          probe_v [2];
    logic [23:0] probe_obs [2];

    // The band shows the last DEPTH samples written before the frame's snapshot, oldest at left;
    // a RAM slot shows whatever sample most recently landed there.
    function automatic logic [23:0] model_pixel(input int hp, input int vp, input bit vd);
        int band, fill, idx;
        logic [DW-1:0] s;
        band = -1;
        if (!vd || hp >= DEPTH) return 24'h0;
        for (int k = 0; k < NCH; k++) begin
            if (vp >= TOP + k * (BH + GAP) && vp < TOP + k * (BH + GAP) + BH) band = k;
        end
        if (band < 0) return 24'h0;
        fill = (snap_cnt[band] < DEPTH) ? snap_cnt[band] : DEPTH;
        if (hp < DEPTH - fill) return 24'h0;
        idx = snap_cnt[band] - DEPTH + hp;
        while (idx + DEPTH < hist_cnt[band]) idx += DEPTH;
        s = hist_mem[band][idx];
        return {3{s[DW-1 -: 8]}};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) begin
            hist_cnt[k] = 0;
            snap_cnt[k] = 0;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One display_clk cycle: drive inputs, queue the expected pixel, compare the pixel from two cycles back.
    task automatic apply_stimulus(input int hp, input int vp, input bit vd,
                                  input logic [NCH-1:0] vmask, input logic [NCH*DW-1:0] data);
        pix_t        e;
        logic [23:0] obs;
        h_pos = 10'(hp);
        v_pos = 10'(vp);
        valid_draw = vd;
        sink.sink_valid = vmask;
        sink.sink_data  = data;
        e.h = hp;
        e.v = vp;
        e.exp = model_pixel(hp, vp, vd);
        exp_q.push_back(e);
        if (hp == 0 && vp == 0) begin
            for (int k = 0; k < NCH; k++) snap_cnt[k] = hist_cnt[k];
        end
        if (!freeze) begin
            for (int k = 0; k < NCH; k++) begin
                if (vmask[k]) begin
                    if (hist_cnt[k] < HIST_MAX) hist_mem[k][hist_cnt[k]] = data[k*DW +: DW];
                    hist_cnt[k]++;
                end
            end
        end
        @(posedge display_clk);
        #1;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            obs = {disp_red, disp_green, disp_blue};
            for (int p = 0; p < 2; p++) begin
                if (e.h == probe_h[p] && e.v == probe_v[p]) probe_obs[p] = obs;
            end
            if (obs !== e.exp) begin
                if (row_bad == 0) begin
                    bad_h = e.h;
                    bad_v = e.v;
                    bad_obs = obs;
                    bad_exp = e.exp;
                end
                row_bad++;
            end
        end
    endtask

    task automatic write_cycle(input logic [NCH-1:0] vmask, input logic [NCH*DW-1:0] data);
        apply_stimulus(1000, 150, 1'b1, vmask, data);
    endtask

    task automatic random_writes(input int n);
        for (int i = 0; i < n; i++) begin
            write_cycle(NCH'($urandom_range(0, (1 << NCH) - 1)), (NCH*DW)'({$urandom(), $urandom()}));
        end
    endtask

    task automatic sweep_row(input int vp);
        row_bad = 0;
        for (int h = 0; h < DEPTH + 8; h++) apply_stimulus(h, vp, (h != 100), '0, '0);
        apply_stimulus(1023, 1023, 1'b0, '0, '0);
        apply_stimulus(1023, 1023, 1'b0, '0, '0);
        n_checks++;
        assert (row_bad === 0) else begin
            n_fails++;
            $error("[TB] FAIL row v=%0d: %0d pixels wrong, first h=%0d v=%0d observed %h expected %h",
                   vp, row_bad, bad_h, bad_v, bad_obs, bad_exp);
        end
    endtask

    task automatic sweep_frame(input bit parity, input bit mid_write, input logic [DW-1:0] mid_data);
        int start;
        apply_stimulus(0, 0, 1'b1, '0, '0);
        for (int k = 0; k < NCH; k++) begin
            if (mid_write && k == 2) write_cycle(NCH'(4), (NCH*DW)'(mid_data) << (2 * DW));
            start = TOP + k * (BH + GAP);
            if (!parity) begin
                sweep_row(start - 1);
                sweep_row(start);
            end else begin
                sweep_row(start + BH - 1);
                sweep_row(start + BH);
            end
        end
    endtask

    task automatic set_probes(input int h0, input int v0, input int h1, input int v1);
        probe_h[0] = h0;
        probe_v[0] = v0;
        probe_h[1] = h1;
        probe_v[1] = v1;
        probe_obs[0] = 24'hxxxxxx;
        probe_obs[1] = 24'hxxxxxx;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NCH*DW-1:0] d;
        sink.sink_valid = '0;
        sink.sink_data  = '0;
        clear_model();
        set_probes(-1, -1, -1, -1);

        $display("[TB] reset and blanking");
        repeat (3) @(posedge display_clk);
        #1;
        check_output("disp_in_reset", 32'({disp_red, disp_green, disp_blue}), 32'h0);
        sweep_frame(1'b0, 1'b0, '0);
        reset_n = 1'b1;
        check_output("ready_after_reset", 32'(sink.sink_ready), 32'hF);

        $display("[TB] single sample on channel 0");
        write_cycle(NCH'(1), (NCH*DW)'(12'hFFF));
        set_probes(479, 32, 478, 32);
        sweep_frame(1'b0, 1'b0, '0);
        check_output("single_col479", 32'(probe_obs[0]), 32'hFFFFFF);
        check_output("single_col478", 32'(probe_obs[1]), 32'h0);

        $display("[TB] full fill and wrap on channel 1");
        for (int i = 0; i < DEPTH; i++) write_cycle(NCH'(2), (NCH*DW)'(i) << DW);
        write_cycle(NCH'(2), (NCH*DW)'(1000) << DW);
        set_probes(479, 96, 300, 96);
        sweep_frame(1'b0, 1'b0, '0);
        check_output("wrap_col479", 32'(probe_obs[0]), 32'h3E3E3E);
        check_output("wrap_col300", 32'(probe_obs[1]), 32'h121212);
        set_probes(-1, -1, -1, -1);

        $display("[TB] random traffic");
        for (int r = 0; r < 3; r++) begin
            random_writes(40);
            sweep_frame(r[0], 1'b0, '0);
        end

        $display("[TB] freeze");
        sweep_frame(1'b1, 1'b0, '0);
        freeze = 1'b1;
        write_cycle('0, '0);
        check_output("ready_frozen", 32'(sink.sink_ready), 32'h0);
        for (int i = 0; i < 50; i++) write_cycle('1, (NCH*DW)'({$urandom(), $urandom()}));
        sweep_frame(1'b0, 1'b0, '0);
        sweep_frame(1'b1, 1'b0, '0);
        freeze = 1'b0;
        write_cycle('0, '0);
        check_output("ready_unfrozen", 32'(sink.sink_ready), 32'hF);

        $display("[TB] mid-frame write on channel 2");
        sweep_frame(1'b0, 1'b1, DW'($urandom()));
        sweep_frame(1'b0, 1'b0, '0);

        $display("[TB] simultaneous writes on all channels");
        for (int i = 0; i < 10; i++) begin
            d = '0;
            for (int k = 0; k < NCH; k++) d[k*DW +: DW] = DW'((k * 16 + i) << 4);
            write_cycle('1, d);
        end
        set_probes(479, 224, 470, 160);
        sweep_frame(1'b0, 1'b0, '0);
        check_output("simul_ch3_col479", 32'(probe_obs[0]), 32'h393939);
        check_output("simul_ch2_col470", 32'(probe_obs[1]), 32'h202020);
        set_probes(-1, -1, -1, -1);

        $display("[TB] reset mid-frame");
        apply_stimulus(0, 0, 1'b1, '0, '0);
        sweep_row(TOP);
        sink.sink_valid = '0;
        reset_n = 1'b0;
        #2;
        check_output("disp_async_clear", 32'({disp_red, disp_green, disp_blue}), 32'h0);
        clear_model();
        exp_q.delete();
        @(posedge display_clk);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k < NCH; k++) sweep_row(TOP + k * (BH + GAP));
        random_writes(30);
        sweep_frame(1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
